// File: rtl/mul4_seq_ctrl_if.sv
// rtl/mul4_seq_ctrl_if.sv - request/response bundle between requester and the 4x4 multiplier
interface mul4_seq_ctrl_if;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mul4_seq_ctrl.sv
// rtl/mul4_seq_ctrl.sv - sequential 4x4 shift-and-add multiplier around a shared 4-bit ripple adder
module Adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic carry;

    always_comb begin
        carry = cin;
        s     = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end
endmodule

module mul4_seq_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    mul4_seq_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] m;
    logic [3:0] a;
    logic [3:0] q;
    logic       c;
    logic [1:0] cnt;
    logic [7:0] product;

    logic [3:0] add_s;
    logic       add_cout;
    logic       sum_c;
    logic [3:0] sum_a;
    logic [3:0] shift_a;
    logic [3:0] shift_q;
    logic [1:0] cnt_inc;
    logic       last_step;

    logic       ready_d;
    logic       busy_d;
    logic       done_d;

    Adder u_adder (
        .x    (a),
        .y    (m),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    // c is cleared on accept and by every shift, so the no-add path keeps {0,A}
    always_comb begin
        sum_c = c;
        sum_a = a;
        if (q[0]) begin
            sum_c = add_cout;
            sum_a = add_s;
        end
        shift_a = {sum_c, sum_a[3:1]};
        shift_q = {sum_a[0], q[3:1]};
    end

    // Two-bit step counter as explicit toggle logic; the shared Adder is the only adder
    always_comb begin
        cnt_inc   = {cnt[1] ^ cnt[0], ~cnt[0]};
        last_step = (cnt == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.start) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                busy_d = 1'b1;
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy_d     = 1'b1;
                done_d     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m       <= '0;
            a       <= '0;
            q       <= '0;
            c       <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        m   <= bus.multiplicand;
                        q   <= bus.multiplier;
                        a   <= '0;
                        c   <= 1'b0;
                        cnt <= '0;
                    end
                end
                S_CALC: begin
                    a   <= shift_a;
                    q   <= shift_q;
                    c   <= 1'b0;
                    cnt <= cnt_inc;
                    if (last_step) begin
                        product <= {shift_a, shift_q};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready   = ready_d;
    assign bus.busy    = busy_d;
    assign bus.done    = done_d;
    assign bus.product = product;
endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// tb/tb_mul4_seq_ctrl.sv - scoreboard bench for mul4_seq_ctrl
module tb_mul4_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mul4_seq_ctrl_if bus ();

    mul4_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_count = 0;
    int         last_done = -1;
    bit         held_mode = 1'b0;
    logic [7:0] expq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_timeout", {31'd0, bus.ready}, 32'd1);
    endtask

    task automatic do_mul(input logic [3:0] mv, input logic [3:0] qv, input logic [7:0] exp);
        wait_ready();
        bus.multiplicand = mv;
        bus.multiplier   = qv;
        bus.start        = 1'b1;
        expq.push_back(exp);
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("ready_after_op", {31'd0, bus.ready}, 32'd1);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_count++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got product %0h with no request outstanding (cycle %0d)", bus.product, cyc);
                end else begin
                    check("product", {24'd0, bus.product}, {24'd0, expq.pop_front()});
                end
                if (held_mode && last_done >= 0) begin
                    check("period", cyc - last_done, 32'd6);
                end
                last_done = cyc;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) tick();
        check("rst_ready",   {31'd0, bus.ready}, 32'd1);
        check("rst_busy",    {31'd0, bus.busy},  32'd0);
        check("rst_done",    {31'd0, bus.done},  32'd0);
        check("rst_product", {24'd0, bus.product}, 32'h00);
        rst_n = 1'b1;
        tick();

        // 9*6 with internal {A,Q} trace
        bus.multiplicand = 4'd9;
        bus.multiplier   = 4'd6;
        bus.start        = 1'b1;
        expq.push_back(8'h36);
        tick();
        bus.start = 1'b0;
        check("e0_ready", {31'd0, bus.ready}, 32'd0);
        check("e0_busy",  {31'd0, bus.busy},  32'd1);
        tick();
        check("e1_aq", {24'd0, dut.a, dut.q}, 32'h03);
        tick();
        check("e2_aq", {24'd0, dut.a, dut.q}, 32'h49);
        tick();
        check("e3_aq", {24'd0, dut.a, dut.q}, 32'h6C);
        check("e3_done", {31'd0, bus.done}, 32'd0);
        tick();
        check("e4_done", {31'd0, bus.done}, 32'd1);
        check("e4_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("e5_ready", {31'd0, bus.ready}, 32'd1);
        check("e5_done",  {31'd0, bus.done},  32'd0);
        check("e5_busy",  {31'd0, bus.busy},  32'd0);
        check("e5_product_hold", {24'd0, bus.product}, 32'h36);

        do_mul(4'd15, 4'd15, 8'hE1);
        do_mul(4'd0,  4'd13, 8'h00);
        do_mul(4'd13, 4'd0,  8'h00);
        do_mul(4'd1,  4'd15, 8'h0F);

        // 7*3 with start pulses during CALC and DONE that must be ignored
        wait_ready();
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd3;
        bus.start        = 1'b1;
        expq.push_back(8'h15);
        tick();
        bus.start = 1'b0;
        tick();
        bus.multiplicand = 4'd2;
        bus.multiplier   = 4'd2;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("ign_in_done", {31'd0, bus.done}, 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign_ready", {31'd0, bus.ready}, 32'd1);
        repeat (8) tick();
        check("ign_product_hold", {24'd0, bus.product}, 32'h15);
        do_mul(4'd2, 4'd2, 8'h04);

        // reset at the second CALC edge of 11*11
        wait_ready();
        bus.multiplicand = 4'd11;
        bus.multiplier   = 4'd11;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_ready",   {31'd0, bus.ready}, 32'd1);
        check("midrst_busy",    {31'd0, bus.busy},  32'd0);
        check("midrst_done",    {31'd0, bus.done},  32'd0);
        check("midrst_product", {24'd0, bus.product}, 32'h00);
        rst_n = 1'b1;
        repeat (6) tick();
        do_mul(4'd11, 4'd11, 8'h79);

        // exhaustive sweep with start held high
        base      = done_count;
        held_mode = 1'b1;
        last_done = -1;
        bus.start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                logic [7:0] p;
                wait_ready();
                bus.multiplicand = i[3:0];
                bus.multiplier   = j[3:0];
                p = 8'(i * j);
                expq.push_back(p);
                tick();
            end
        end
        bus.start = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        tick();
        held_mode = 1'b0;
        check("sweep_done_count", done_count - base, 32'd256);
        check("queue_empty", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
